scalar_broadcast_unit: RTL and testbench
========================================

SCALAR_BROADCAST_UNIT -- requirements
Module: scalar_broadcast_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, scalar width (32 or 64).
REQ-002 SHALL have parameter VLEN, default 512, vector register width in bits.
REQ-003 SHALL have parameter OUT_W, default 128, output beat width; VLEN multiple of OUT_W, OUT_W multiple of 64.
REQ-004 SHALL have derived localparams BEATS = VLEN/OUT_W, VL_W = $clog2(VLEN/8)+1, BI_W = max(1,$clog2(BEATS)).
REQ-005 SHALL have port clk_i  input  1  clock; single clock domain, rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port chip_enable  input  1  block enable.
REQ-008 SHALL have port in_valid_i  input  1  request valid.
REQ-009 SHALL have port in_ready_o  output  1  request accepted when high with in_valid_i.
REQ-010 SHALL have port rs1_i  input  XLEN  scalar operand.
REQ-011 SHALL have port imm_i  input  5  immediate operand.
REQ-012 SHALL have port src_sel_i  input  1  0 = rs1_i, 1 = imm_i.
REQ-013 SHALL have port imm_signed_i  input  1  1 = sign-extend imm_i, 0 = zero-extend.
REQ-014 SHALL have port vsew_i  input  2  SEW: 00=8, 01=16, 10=32, 11=64.
REQ-015 SHALL have port vl_i  input  VL_W  active element count.
REQ-016 SHALL have port out_valid_o  output  1  beat valid.
REQ-017 SHALL have port out_ready_i  input  1  beat consumed when high with out_valid_o.
REQ-018 SHALL have port v_rs1_o  output  OUT_W  beat data, element 0 in LSBs.
REQ-019 SHALL have port beat_idx_o  output  BI_W  current beat index.
REQ-020 SHALL have port last_o  output  1  high on beat BEATS-1.

Function
REQ-021 SHALL implement states IDLE and BUSY; IDLE->BUSY on accept; BUSY->IDLE on handshake of last beat unless a new request is accepted that cycle (stays BUSY, beat index 0).
REQ-022 SHALL drive in_ready_o = chip_enable & (IDLE | (BUSY & last_o & out_ready_i)); no bubble between back-to-back requests.
REQ-023 SHALL register operand, SEW, vl and source on accept; later input changes do not affect the current request.
REQ-024 SHALL assert out_valid_o the cycle after accept (latency 1) and hold it through all BEATS beats.
REQ-025 SHALL increment beat index only on out_valid_o & out_ready_i; data and beat_idx_o held stable while out_ready_i low.
REQ-026 SHALL form element value: rs1_i truncated to SEW, or sign-extended to SEW when SEW > XLEN; imm_i sign- or zero-extended to SEW per imm_signed_i.
REQ-027 SHALL replicate element value across all OUT_W/SEW element slots of each beat; beat b covers global elements b*(OUT_W/SEW) upward.
REQ-028 SHALL saturate vl to VLMAX = VLEN/SEW when vl exceeds it; vl=0 still emits BEATS beats.
REQ-029 SHALL drive v_rs1_o = 0 whenever out_valid_o low.
REQ-030 SHALL, with chip_enable low in BUSY, force out_valid_o and in_ready_o to 0 and freeze state and beat index; resume unchanged when re-enabled.

Reset
REQ-031 SHALL on rst_i go to IDLE: out_valid_o=0, v_rs1_o=0, beat_idx_o=0, last_o=0, captured registers 0.
REQ-032 SHALL abort any in-flight request on reset mid-operation; no further beats of it emitted.
REQ-033 SHALL present in_ready_o = chip_enable in the first cycle after reset release.

Configuration
REQ-034 SHALL with macro SBU_TAIL_ZERO_EN defined, drive 0 in every element slot whose global index >= saturated vl.
REQ-035 SHALL without SBU_TAIL_ZERO_EN, ignore vl_i and fill all element slots with the element value.

Verification (VLEN=512, OUT_W=128, XLEN=64, BEATS=4)
REQ-036 SHALL cover rs1=0x0123456789ABCDEF, vsew=00, vl=64 -> 4 beats of 0xEFEF...EF, last_o on beat 3 only.
REQ-037 SHALL cover src_sel=1, imm=0x1F, vsew=10: signed -> 0xFFFFFFFF per element; unsigned -> 0x0000001F per element.
REQ-038 SHALL cover vsew=11, vl=3, rs1=R with SBU_TAIL_ZERO_EN -> beat0 {R,R}, beat1 {0,R}, beats 2-3 zero; without macro all beats {R,R}.
REQ-039 SHALL cover out_ready_i low 3 cycles on beat 1 -> v_rs1_o and beat_idx_o=1 stable, no beat lost or duplicated.
REQ-040 SHALL cover new in_valid_i during last-beat handshake -> accepted same cycle, next request beat 0 valid next cycle.
REQ-041 SHALL cover rst_i pulse during beat 2 -> out_valid_o=0 immediately, in_ready_o=1 after release, no residual beats.

Source files
------------

// File: rtl/scalar_broadcast_unit.sv
// ---------------------------------------------------------------------------
// scalar_broadcast_unit
//
// Purpose:
//   Takes one scalar operand, either rs1 or a 5-bit immediate, and turns it
//   into a full vector register image. The operand is sized to the selected
//   element width (SEW) and copied into every element slot. The image is
//   streamed out as BEATS beats of OUT_W bits each, with element 0 in the
//   LSBs of beat 0.
//
// Optional feature (compile-time macro SBU_TAIL_ZERO_EN):
//   When defined, element slots whose global index is at or beyond the
//   saturated vl are driven to zero.
//   When undefined, vl_i is ignored and every slot carries the element value.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_i         asynchronous active-high reset
//   chip_enable   block enable; when low the output stream pauses in place
//   in_valid_i    request valid
//   in_ready_o    request accepted when high together with in_valid_i
//   rs1_i         scalar operand (XLEN bits)
//   imm_i         5-bit immediate operand
//   src_sel_i     0 = rs1_i, 1 = imm_i
//   imm_signed_i  1 = sign-extend imm_i, 0 = zero-extend imm_i
//   vsew_i        element width: 00=8, 01=16, 10=32, 11=64
//   vl_i          active element count
//   out_valid_o   beat valid
//   out_ready_i   beat consumed when high together with out_valid_o
//   v_rs1_o       beat data; zero whenever out_valid_o is low
//   beat_idx_o    index of the beat currently presented
//   last_o        high while the final beat is presented
// ---------------------------------------------------------------------------
module scalar_broadcast_unit #(
  parameter  int XLEN  = 64,
  parameter  int VLEN  = 512,
  parameter  int OUT_W = 128,
  localparam int BEATS = VLEN / OUT_W,
  localparam int VL_W  = $clog2(VLEN / 8) + 1,
  localparam int BI_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             chip_enable,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [4:0]       imm_i,
  input  logic             src_sel_i,
  input  logic             imm_signed_i,
  input  logic [1:0]       vsew_i,
  input  logic [VL_W-1:0]  vl_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] v_rs1_o,
  output logic [BI_W-1:0]  beat_idx_o,
  output logic             last_o
);

  // Number of byte lanes in one output beat.
  localparam int BYTES_PB = OUT_W / 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_reg;
  logic [BI_W-1:0] beat_idx_reg;
  logic [63:0]     elem_reg;   // element value, already sized to SEW
  logic [1:0]      sew_reg;

  logic [63:0]     elem_next;
  logic [63:0]     rs1_ext;
  logic [63:0]     imm_ext;
  logic            out_valid;
  logic            last_beat;
  logic            accept;
  logic            handshake;
  logic [OUT_W-1:0] rep_data;
  logic [OUT_W-1:0] beat_data;

  // ------------------------------------------------------------------
  // Element formation at accept time.
  // ------------------------------------------------------------------
  // rs1 is sign-extended to 64 bits. When SEW <= XLEN only the low SEW
  // bits are ever used, so this is simply a truncation. When SEW = 64
  // and XLEN = 32, it gives the required sign extension.
  always_comb begin
    rs1_ext = 64'($signed(rs1_i));
    if (imm_signed_i) begin
      imm_ext = 64'($signed(imm_i));
    end else begin
      imm_ext = 64'(imm_i);
    end
    elem_next = src_sel_i ? imm_ext : rs1_ext;
  end

  // ------------------------------------------------------------------
  // Handshake logic.
  // ------------------------------------------------------------------
  // Disabling the block hides the stream without touching the state, so
  // the same beat is presented again once chip_enable returns.
  assign out_valid  = chip_enable & (state_reg == BUSY);
  assign last_beat  = (beat_idx_reg == BI_W'(BEATS - 1));
  assign last_o     = out_valid & last_beat;

  // A new request may land on the cycle the final beat is consumed.
  // This keeps back-to-back requests free of bubbles.
  assign in_ready_o = chip_enable & ((state_reg == IDLE) | (last_o & out_ready_i));
  assign accept     = in_valid_i & in_ready_o;
  assign handshake  = out_valid & out_ready_i;

`ifdef SBU_TAIL_ZERO_EN
  logic [VL_W-1:0] vl_reg;
  logic [VL_W-1:0] vlmax_next;
  logic [VL_W-1:0] vl_sat_next;

  // VLMAX = VLEN/SEW = (VLEN/8) >> vsew.
  always_comb begin
    vlmax_next  = VL_W'((VLEN / 8) >> vsew_i);
    vl_sat_next = (vl_i > vlmax_next) ? vlmax_next : vl_i;
  end
`else
  // vl only matters when tail zeroing is built in.
  logic unused_vl;
  assign unused_vl = ^vl_i;
`endif

  // ------------------------------------------------------------------
  // Control state machine and captured request.
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      beat_idx_reg <= '0;
      elem_reg     <= '0;
      sew_reg      <= '0;
`ifdef SBU_TAIL_ZERO_EN
      vl_reg       <= '0;
`endif
    end else begin
      if (accept) begin
        // A new request always starts at beat 0. This includes the case
        // where it overlaps the last beat of the previous request.
        state_reg    <= BUSY;
        beat_idx_reg <= '0;
        elem_reg     <= elem_next;
        sew_reg      <= vsew_i;
`ifdef SBU_TAIL_ZERO_EN
        vl_reg       <= vl_sat_next;
`endif
      end else if (handshake) begin
        if (last_beat) begin
          state_reg    <= IDLE;
          beat_idx_reg <= '0;
        end else begin
          beat_idx_reg <= beat_idx_reg + 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Replication of the element across a beat.
  // ------------------------------------------------------------------
  always_comb begin
    rep_data = '0;
    case (sew_reg)
      2'b00:   rep_data = {(OUT_W / 8){elem_reg[7:0]}};
      2'b01:   rep_data = {(OUT_W / 16){elem_reg[15:0]}};
      2'b10:   rep_data = {(OUT_W / 32){elem_reg[31:0]}};
      default: rep_data = {(OUT_W / 64){elem_reg[63:0]}};
    endcase
  end

`ifdef SBU_TAIL_ZERO_EN
  // Each byte lane works out the global index of the element it belongs
  // to. It keeps its byte only if that index is below the saturated vl.
  //   elements per beat      = BYTES_PB >> sew
  //   element within the beat = lane >> sew
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PB; gi++) begin : g_lane
      logic [31:0] elem_gidx;
      logic        lane_keep;
      assign elem_gidx = 32'(beat_idx_reg) * (32'(BYTES_PB) >> sew_reg)
                       + (32'(gi) >> sew_reg);
      assign lane_keep = (elem_gidx < 32'(vl_reg));
      assign beat_data[gi*8 +: 8] = lane_keep ? rep_data[gi*8 +: 8] : 8'd0;
    end
  endgenerate
`else
  assign beat_data = rep_data;
`endif

  // ------------------------------------------------------------------
  // Outputs.
  // ------------------------------------------------------------------
  assign out_valid_o = out_valid;
  assign beat_idx_o  = beat_idx_reg;
  assign v_rs1_o     = out_valid ? beat_data : '0;

endmodule

// File: tb/tb_scalar_broadcast_unit.sv
// ---------------------------------------------------------------------------
// tb_scalar_broadcast_unit
//
// Directed test of scalar_broadcast_unit with the default configuration:
// XLEN=64, VLEN=512, OUT_W=128, BEATS=4.
// Inputs are driven just after the rising edge or at the falling edge.
// Outputs are sampled at the falling edge.
// Expected results for the tail test depend on SBU_TAIL_ZERO_EN.
// ---------------------------------------------------------------------------
module tb_scalar_broadcast_unit;

  localparam int XLEN  = 64;
  localparam int VLEN  = 512;
  localparam int OUT_W = 128;
  localparam int VL_W  = 7;
  localparam int BI_W  = 2;

  logic             clk_i;
  logic             rst_i;
  logic             chip_enable;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [XLEN-1:0]  rs1_i;
  logic [4:0]       imm_i;
  logic             src_sel_i;
  logic             imm_signed_i;
  logic [1:0]       vsew_i;
  logic [VL_W-1:0]  vl_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [OUT_W-1:0] v_rs1_o;
  logic [BI_W-1:0]  beat_idx_o;
  logic             last_o;

  int n_checks;
  int n_fails;

  scalar_broadcast_unit #(
    .XLEN  (XLEN),
    .VLEN  (VLEN),
    .OUT_W (OUT_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .chip_enable  (chip_enable),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .rs1_i        (rs1_i),
    .imm_i        (imm_i),
    .src_sel_i    (src_sel_i),
    .imm_signed_i (imm_signed_i),
    .vsew_i       (vsew_i),
    .vl_i         (vl_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .v_rs1_o      (v_rs1_o),
    .beat_idx_o   (beat_idx_o),
    .last_o       (last_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check_value(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Checks the currently presented beat, without waiting.
  task automatic check_beat(input string tag, input int b, input logic [127:0] exp_data);
    check_value({tag, "_valid"}, 128'(out_valid_o), 128'(1));
    check_value({tag, "_idx"},   128'(beat_idx_o),  128'(b));
    check_value({tag, "_data"},  v_rs1_o,           exp_data);
    check_value({tag, "_last"},  128'(last_o),      128'(b == 3));
  endtask

  task automatic drive_req(input logic sel, input logic [63:0] rs1, input logic [4:0] imm,
                           input logic sgn, input logic [1:0] sew, input logic [6:0] vl);
    in_valid_i   = 1'b1;
    src_sel_i    = sel;
    rs1_i        = rs1;
    imm_i        = imm;
    imm_signed_i = sgn;
    vsew_i       = sew;
    vl_i         = vl;
  endtask

  // After the accept edge, the inputs are loaded with junk. This shows
  // that the captured request is not affected by later input changes.
  task automatic scramble_inputs();
    in_valid_i   = 1'b0;
    rs1_i        = 64'hFFFF_0000_AAAA_5555;
    imm_i        = 5'h0A;
    src_sel_i    = ~src_sel_i;
    imm_signed_i = ~imm_signed_i;
    vsew_i       = ~vsew_i;
    vl_i         = 7'd1;
  endtask

  task automatic send_req(input string tag, input logic sel, input logic [63:0] rs1,
                          input logic [4:0] imm, input logic sgn, input logic [1:0] sew,
                          input logic [6:0] vl);
    @(negedge clk_i);
    check_value({tag, "_in_ready"}, 128'(in_ready_o), 128'(1));
    drive_req(sel, rs1, imm, sgn, sew, vl);
    @(posedge clk_i);
    #1;
    scramble_inputs();
  endtask

  // Consumes the beats from index first up to index 3, with out_ready
  // held high. Afterwards it checks that the stream has gone idle.
  task automatic run_beats(input string tag, input int first, input logic [127:0] e0,
                           input logic [127:0] e1, input logic [127:0] e2,
                           input logic [127:0] e3);
    logic [127:0] exp_arr [4];
    exp_arr[0] = e0;
    exp_arr[1] = e1;
    exp_arr[2] = e2;
    exp_arr[3] = e3;
    for (int b = first; b < 4; b++) begin
      @(negedge clk_i);
      check_beat($sformatf("%s_b%0d", tag, b), b, exp_arr[b]);
      @(posedge clk_i);
    end
    @(negedge clk_i);
    check_value({tag, "_done_valid"}, 128'(out_valid_o), 128'(0));
    check_value({tag, "_done_data"},  v_rs1_o,           128'(0));
    $display("transaction %s: beats %0d..3 checked", tag, first);
  endtask

  localparam logic [63:0] R_TAIL = 64'hDEAD_BEEF_CAFE_F00D;

  logic [127:0] tail_b0, tail_b1, tail_b2, tail_b3;

  initial begin
    n_checks     = 0;
    n_fails      = 0;
    rst_i        = 1'b1;
    chip_enable  = 1'b1;
    in_valid_i   = 1'b0;
    out_ready_i  = 1'b1;
    rs1_i        = '0;
    imm_i        = '0;
    src_sel_i    = 1'b0;
    imm_signed_i = 1'b0;
    vsew_i       = 2'b00;
    vl_i         = '0;

    // Reset state.
    repeat (2) @(negedge clk_i);
    check_value("rst_valid", 128'(out_valid_o), 128'(0));
    check_value("rst_data",  v_rs1_o,           128'(0));
    check_value("rst_idx",   128'(beat_idx_o),  128'(0));
    check_value("rst_last",  128'(last_o),      128'(0));
    rst_i = 1'b0;
    @(negedge clk_i);
    check_value("post_rst_ready", 128'(in_ready_o), 128'(1));
    $display("transaction reset: checked");

    // SEW=8 broadcast of the low byte of rs1.
    send_req("sew8", 1'b0, 64'h0123_4567_89AB_CDEF, 5'h00, 1'b0, 2'b00, 7'd64);
    run_beats("sew8", 0, {16{8'hEF}}, {16{8'hEF}}, {16{8'hEF}}, {16{8'hEF}});

    // Immediate 0x1F at SEW=32, first signed and then unsigned.
    // A vl above VLMAX saturates, so every element stays active.
    send_req("imm_s", 1'b1, 64'h0, 5'h1F, 1'b1, 2'b10, 7'd64);
    run_beats("imm_s", 0, {4{32'hFFFF_FFFF}}, {4{32'hFFFF_FFFF}},
              {4{32'hFFFF_FFFF}}, {4{32'hFFFF_FFFF}});
    send_req("imm_u", 1'b1, 64'h0, 5'h1F, 1'b0, 2'b10, 7'd64);
    run_beats("imm_u", 0, {4{32'h0000_001F}}, {4{32'h0000_001F}},
              {4{32'h0000_001F}}, {4{32'h0000_001F}});

    // SEW=64 with vl=3, exercising tail handling.
`ifdef SBU_TAIL_ZERO_EN
    tail_b0 = {R_TAIL, R_TAIL};
    tail_b1 = {64'h0, R_TAIL};
    tail_b2 = 128'h0;
    tail_b3 = 128'h0;
`else
    tail_b0 = {R_TAIL, R_TAIL};
    tail_b1 = {R_TAIL, R_TAIL};
    tail_b2 = {R_TAIL, R_TAIL};
    tail_b3 = {R_TAIL, R_TAIL};
`endif
    send_req("tail", 1'b0, R_TAIL, 5'h00, 1'b0, 2'b11, 7'd3);
    run_beats("tail", 0, tail_b0, tail_b1, tail_b2, tail_b3);

    // Back-pressure: out_ready is held low for 3 cycles on beat 1.
    send_req("stall", 1'b0, 64'h0000_0000_0000_A55A, 5'h00, 1'b0, 2'b01, 7'd100);
    @(negedge clk_i);
    check_beat("stall_b0", 0, {8{16'hA55A}});
    @(posedge clk_i);
    @(negedge clk_i);
    out_ready_i = 1'b0;
    check_beat("stall_b1", 1, {8{16'hA55A}});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      check_beat($sformatf("stall_hold%0d", i), 1, {8{16'hA55A}});
    end
    out_ready_i = 1'b1;
    @(posedge clk_i);
    run_beats("stall", 2, 128'h0, 128'h0, {8{16'hA55A}}, {8{16'hA55A}});

    // Back-to-back: the next request is accepted on the last-beat handshake.
    send_req("b2b_a", 1'b0, 64'h0000_0000_0000_003C, 5'h00, 1'b0, 2'b00, 7'd64);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk_i);
      check_beat($sformatf("b2b_a_b%0d", b), b, {16{8'h3C}});
      @(posedge clk_i);
    end
    @(negedge clk_i);
    check_beat("b2b_a_b3", 3, {16{8'h3C}});
    check_value("b2b_ready_last", 128'(in_ready_o), 128'(1));
    drive_req(1'b0, 64'h1111_2222_89AB_CDEF, 5'h00, 1'b0, 2'b10, 7'd64);
    @(posedge clk_i);
    #1;
    scramble_inputs();
    $display("transaction b2b_a: beats 0..3 checked");
    run_beats("b2b_b", 0, {4{32'h89AB_CDEF}}, {4{32'h89AB_CDEF}},
              {4{32'h89AB_CDEF}}, {4{32'h89AB_CDEF}});

    // Disable during the last beat: the stream is hidden, then resumes in place.
    send_req("ce", 1'b0, 64'h0000_0000_0000_0077, 5'h00, 1'b0, 2'b00, 7'd64);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk_i);
      check_beat($sformatf("ce_b%0d", b), b, {16{8'h77}});
      @(posedge clk_i);
    end
    @(negedge clk_i);
    check_beat("ce_b3", 3, {16{8'h77}});
    chip_enable = 1'b0;
    #1;
    check_value("ce_off_valid", 128'(out_valid_o), 128'(0));
    check_value("ce_off_ready", 128'(in_ready_o),  128'(0));
    check_value("ce_off_last",  128'(last_o),      128'(0));
    check_value("ce_off_data",  v_rs1_o,           128'(0));
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_value("ce_frozen_idx", 128'(beat_idx_o), 128'(3));
    chip_enable = 1'b1;
    #1;
    check_beat("ce_resume_b3", 3, {16{8'h77}});
    @(posedge clk_i);
    @(negedge clk_i);
    check_value("ce_done_valid", 128'(out_valid_o), 128'(0));
    $display("transaction ce: disable and resume checked");

    // Reset pulse during beat 2 aborts the request.
    send_req("rst_mid", 1'b0, 64'h0000_0000_0000_00C3, 5'h00, 1'b0, 2'b00, 7'd64);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk_i);
      check_beat($sformatf("rst_mid_b%0d", b), b, {16{8'hC3}});
      @(posedge clk_i);
    end
    @(negedge clk_i);
    check_beat("rst_mid_b2", 2, {16{8'hC3}});
    rst_i = 1'b1;
    #1;
    check_value("rst_mid_valid", 128'(out_valid_o), 128'(0));
    check_value("rst_mid_data",  v_rs1_o,           128'(0));
    check_value("rst_mid_idx",   128'(beat_idx_o),  128'(0));
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_value($sformatf("rst_after_valid%0d", i), 128'(out_valid_o), 128'(0));
      check_value($sformatf("rst_after_ready%0d", i), 128'(in_ready_o),  128'(1));
    end
    $display("transaction rst_mid: abort checked");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
